// File: rtl/omsp_atom_violation_handler.sv
// Atomicity violation handler: logs the first violation, drives an abort
// handshake through DRAIN/ABORT, and tracks how long IRQs are held off by gie=0.
module omsp_atom_violation_handler #(
    parameter int CNT_W        = 8,
    parameter int DEFER_W      = 16,
    parameter int DRAIN_CYCLES = 3,
    parameter int DEFER_LIMIT  = 64
) (
    input  logic               mclk,
    input  logic               puc_rst,
    input  logic               atom_violation,
    input  logic               gie,
    input  logic               irq_pending,
    input  logic [15:0]        sm_id,
    input  logic [15:0]        cur_pc,
    input  logic               abort_ack,
    input  logic               viol_clear,
    output logic               viol_abort_req,
    output logic               viol_valid,
    output logic               viol_overrun,
    output logic [15:0]        viol_sm_id,
    output logic [15:0]        viol_pc,
    output logic [CNT_W-1:0]   viol_count,
    output logic [DEFER_W-1:0] irq_defer_max,
    output logic               irq_defer_violation
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_ABORT
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         drain_q, drain_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic [15:0]        sm_q, sm_d;
    logic [15:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DEFER_W-1:0] dcnt_q, dcnt_d;
    logic [DEFER_W-1:0] dmax_q, dmax_d;
    logic               dpulse_q, dpulse_d;

    logic [CNT_W-1:0]   cnt_inc;
    logic [DEFER_W-1:0] dcnt_inc;
    logic               active;
    logic               dcnt_sat;

    assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign dcnt_sat = (dcnt_q == '1);
    assign dcnt_inc = dcnt_sat ? dcnt_q : dcnt_q + 1'b1;
    assign active   = irq_pending & ~gie;

    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        sm_d     = sm_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        dcnt_d   = dcnt_q;
        dmax_d   = dmax_q;
        dpulse_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (atom_violation) begin
                    sm_d    = sm_id;
                    pc_d    = cur_pc;
                    valid_d = 1'b1;
                    cnt_d   = viol_clear ? CNT_W'(1) : cnt_inc;
                    ovr_d   = viol_clear ? 1'b0 : ovr_q;
                    drain_d = 8'(DRAIN_CYCLES - 1);
                    state_d = S_DRAIN;
                end else if (viol_clear) begin
                    sm_d    = '0;
                    pc_d    = '0;
                    valid_d = 1'b0;
                    ovr_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (drain_q == 8'd0) begin
                    state_d = S_ABORT;
                end else begin
                    drain_d = drain_q - 8'd1;
                end
            end
            S_ABORT: begin
                if (abort_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Late violations are only counted; the first log entry is preserved.
        if (state_q != S_IDLE && atom_violation) begin
            cnt_d = cnt_inc;
            ovr_d = 1'b1;
        end

        if (active) begin
            dcnt_d   = dcnt_inc;
            dpulse_d = !dcnt_sat && (dcnt_q == DEFER_W'(DEFER_LIMIT));
        end else begin
            dcnt_d = '0;
            if (dcnt_q > dmax_q) begin
                dmax_d = dcnt_q;
            end
        end

        if (state_q == S_IDLE && viol_clear) begin
            dmax_d = '0;
        end
    end

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q  <= S_IDLE;
            drain_q  <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            sm_q     <= '0;
            pc_q     <= '0;
            cnt_q    <= '0;
            dcnt_q   <= '0;
            dmax_q   <= '0;
            dpulse_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            sm_q     <= sm_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            dcnt_q   <= dcnt_d;
            dmax_q   <= dmax_d;
            dpulse_q <= dpulse_d;
        end
    end

    assign viol_abort_req      = (state_q == S_ABORT);
    assign viol_valid          = valid_q;
    assign viol_overrun        = ovr_q;
    assign viol_sm_id          = sm_q;
    assign viol_pc             = pc_q;
    assign viol_count          = cnt_q;
    assign irq_defer_max       = dmax_q;
    assign irq_defer_violation = dpulse_q;

endmodule

// File: tb/tb_omsp_atom_violation_handler.sv
// Self-checking bench for omsp_atom_violation_handler: vector table for the
// abort handshake plus hand-built sequences for deferral, saturation and reset.
module tb_omsp_atom_violation_handler;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        atom_violation;
    logic        gie;
    logic        irq_pending;
    logic [15:0] sm_id;
    logic [15:0] cur_pc;
    logic        abort_ack;
    logic        viol_clear;
    logic        viol_abort_req;
    logic        viol_valid;
    logic        viol_overrun;
    logic [15:0] viol_sm_id;
    logic [15:0] viol_pc;
    logic [7:0]  viol_count;
    logic [15:0] irq_defer_max;
    logic        irq_defer_violation;

    int checks = 0;
    int errors = 0;

    always #5 mclk = ~mclk;

    omsp_atom_violation_handler #(
        .CNT_W(8),
        .DEFER_W(16),
        .DRAIN_CYCLES(3),
        .DEFER_LIMIT(64)
    ) dut (
        .mclk(mclk),
        .puc_rst(puc_rst),
        .atom_violation(atom_violation),
        .gie(gie),
        .irq_pending(irq_pending),
        .sm_id(sm_id),
        .cur_pc(cur_pc),
        .abort_ack(abort_ack),
        .viol_clear(viol_clear),
        .viol_abort_req(viol_abort_req),
        .viol_valid(viol_valid),
        .viol_overrun(viol_overrun),
        .viol_sm_id(viol_sm_id),
        .viol_pc(viol_pc),
        .viol_count(viol_count),
        .irq_defer_max(irq_defer_max),
        .irq_defer_violation(irq_defer_violation)
    );

    // Inputs applied before an edge and the outputs required just after it.
    typedef struct {
        logic        rst, viol, gie, irqp, ack, clr;
        logic [15:0] sm, pc;
        logic        req, valid, ovr;
        logic [7:0]  cnt;
        logic [15:0] vsm, vpc, dmax;
        logic        dpulse;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    string cur_name;

    function automatic vec_t mk(
        logic rst, logic viol, logic ack, logic clr,
        logic [15:0] sm, logic [15:0] pc,
        logic req, logic valid, logic ovr, logic [7:0] cnt,
        logic [15:0] vsm, logic [15:0] vpc
    );
        vec_t v;
        v.rst = rst; v.viol = viol; v.gie = 1'b1; v.irqp = 1'b0;
        v.ack = ack; v.clr = clr; v.sm = sm; v.pc = pc;
        v.req = req; v.valid = valid; v.ovr = ovr; v.cnt = cnt;
        v.vsm = vsm; v.vpc = vpc; v.dmax = 16'd0; v.dpulse = 1'b0;
        return v;
    endfunction

    task automatic chk(string f, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %0h required %0h", cur_name, f, act, req);
        end
    endtask

    task automatic step(vec_t v);
        vec_t e;
        puc_rst        = v.rst;
        atom_violation = v.viol;
        gie            = v.gie;
        irq_pending    = v.irqp;
        abort_ack      = v.ack;
        viol_clear     = v.clr;
        sm_id          = v.sm;
        cur_pc         = v.pc;
        exp_q.push_back(v);
        @(posedge mclk);
        #1;
        e = exp_q.pop_front();
        chk("req", 32'(viol_abort_req), 32'(e.req));
        chk("valid", 32'(viol_valid), 32'(e.valid));
        chk("overrun", 32'(viol_overrun), 32'(e.ovr));
        chk("count", 32'(viol_count), 32'(e.cnt));
        chk("sm_id", 32'(viol_sm_id), 32'(e.vsm));
        chk("pc", 32'(viol_pc), 32'(e.vpc));
        chk("defer_max", 32'(irq_defer_max), 32'(e.dmax));
        chk("defer_pulse", 32'(irq_defer_violation), 32'(e.dpulse));
    endtask

    vec_t v;
    int   ecnt;

    initial begin
        // rst viol ack clr sm pc | req valid ovr cnt vsm vpc
        tbl.push_back(mk(1,0,0,0,0,0,           0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,           0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,5,16'h8A42,    0,1,0,1,5,16'h8A42));
        tbl.push_back(mk(0,0,0,0,0,0,           0,1,0,1,5,16'h8A42));
        tbl.push_back(mk(0,0,0,0,0,0,           0,1,0,1,5,16'h8A42));
        tbl.push_back(mk(0,0,0,0,0,0,           1,1,0,1,5,16'h8A42));
        tbl.push_back(mk(0,0,0,0,0,0,           1,1,0,1,5,16'h8A42));
        tbl.push_back(mk(0,0,1,0,0,0,           0,1,0,1,5,16'h8A42));
        tbl.push_back(mk(0,0,0,1,0,0,           0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,0,7,16'h1234,    0,1,0,1,7,16'h1234));
        tbl.push_back(mk(0,1,0,0,9,16'hFFFF,    0,1,1,2,7,16'h1234));
        tbl.push_back(mk(0,0,0,0,0,0,           0,1,1,2,7,16'h1234));
        tbl.push_back(mk(0,0,0,0,0,0,           1,1,1,2,7,16'h1234));
        tbl.push_back(mk(0,1,0,1,10,16'hAAAA,   1,1,1,3,7,16'h1234));
        tbl.push_back(mk(0,1,1,0,11,16'hBBBB,   0,1,1,4,7,16'h1234));
        tbl.push_back(mk(0,0,0,0,0,0,           0,1,1,4,7,16'h1234));
        tbl.push_back(mk(0,0,0,0,0,0,           0,1,1,4,7,16'h1234));
        tbl.push_back(mk(0,0,0,0,0,0,           0,1,1,4,7,16'h1234));
        tbl.push_back(mk(0,0,1,0,0,0,           0,1,1,4,7,16'h1234));
        tbl.push_back(mk(0,0,0,1,0,0,           0,0,0,0,0,0));
        tbl.push_back(mk(0,1,0,1,3,16'h0100,    0,1,0,1,3,16'h0100));
        tbl.push_back(mk(0,0,0,0,0,0,           0,1,0,1,3,16'h0100));
        tbl.push_back(mk(0,0,0,0,0,0,           0,1,0,1,3,16'h0100));
        tbl.push_back(mk(0,0,0,0,0,0,           1,1,0,1,3,16'h0100));
        tbl.push_back(mk(0,0,1,0,0,0,           0,1,0,1,3,16'h0100));

        foreach (tbl[i]) begin
            cur_name = $sformatf("vec%0d", i);
            step(tbl[i]);
        end

        // IRQ deferral: 70-cycle hold-off, pulse on the 65th active cycle.
        v = mk(0,0,0,0,0,0, 0,1,0,1,3,16'h0100);
        v.gie = 1'b0;
        v.irqp = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            cur_name = $sformatf("defer70_c%0d", i);
            v.dpulse = (i == 65);
            step(v);
        end
        v.gie = 1'b1;
        v.dpulse = 1'b0;
        v.dmax = 16'd70;
        cur_name = "defer70_end";
        step(v);
        cur_name = "defer_zero_len";
        step(v);
        v.gie = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cur_name = $sformatf("defer10_c%0d", i);
            step(v);
        end
        v.gie = 1'b1;
        cur_name = "defer10_end";
        step(v);
        v.irqp = 1'b0;
        cur_name = "defer_idle";
        step(v);

        cur_name = "clear_all";
        step(mk(0,0,0,1,0,0, 0,0,0,0,0,0));
        v = mk(0,0,0,0,0,0, 0,0,0,0,0,0);
        v.gie = 1'b0;
        v.irqp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cur_name = "defer3";
            step(v);
        end
        v.gie = 1'b1;
        v.dmax = 16'd3;
        cur_name = "defer3_end";
        step(v);
        cur_name = "clear_max";
        step(mk(0,0,0,1,0,0, 0,0,0,0,0,0));

        // Counter saturation across 256 acknowledged violations.
        for (int k = 1; k <= 256; k++) begin
            ecnt = (k < 255) ? k : 255;
            cur_name = $sformatf("sat_v%0d", k);
            step(mk(0,1,0,0,16'(k),16'(2*k), 0,1,0,8'(ecnt),16'(k),16'(2*k)));
            step(mk(0,0,0,0,0,0, 0,1,0,8'(ecnt),16'(k),16'(2*k)));
            step(mk(0,0,0,0,0,0, 0,1,0,8'(ecnt),16'(k),16'(2*k)));
            step(mk(0,0,0,0,0,0, 1,1,0,8'(ecnt),16'(k),16'(2*k)));
            step(mk(0,0,1,0,0,0, 0,1,0,8'(ecnt),16'(k),16'(2*k)));
        end

        // Reset while in ABORT with an open deferral episode.
        cur_name = "rst_pre";
        step(mk(0,0,0,1,0,0, 0,0,0,0,0,0));
        v = mk(0,1,0,0,16'h0022,16'h4444, 0,1,0,1,16'h0022,16'h4444);
        v.gie = 1'b0;
        v.irqp = 1'b1;
        step(v);
        v.viol = 1'b0;
        step(v);
        step(v);
        v.req = 1'b1;
        cur_name = "rst_in_abort";
        step(v);
        v = mk(1,0,0,0,0,0, 0,0,0,0,0,0);
        v.gie = 1'b0;
        v.irqp = 1'b1;
        cur_name = "rst_edge";
        step(v);
        v.rst = 1'b0;
        v.gie = 1'b1;
        cur_name = "rst_after";
        step(v);
        cur_name = "rst_fresh";
        step(mk(0,1,0,0,5,16'h8A42, 0,1,0,1,5,16'h8A42));
        step(mk(0,0,0,0,0,0,        0,1,0,1,5,16'h8A42));
        step(mk(0,0,0,0,0,0,        0,1,0,1,5,16'h8A42));
        step(mk(0,0,0,0,0,0,        1,1,0,1,5,16'h8A42));
        step(mk(0,0,1,0,0,0,        0,1,0,1,5,16'h8A42));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
